// File: rtl/cpu_step_sequencer.sv
// Multi-cycle fetch/execute/memory sequencer for the RV32 core datapath.
// Optional performance counters are enabled by defining CPU_SEQ_PERF_EN.
module cpu_step_sequencer #(
  parameter int          XLEN         = 32,
  parameter int          IMEM_TIMEOUT = 255,
  parameter logic [31:0] NOP_CMD      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_addr,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_data,
  output logic [31:0]     cmd,
  input  logic            is_load,
  input  logic            is_store,
  input  logic            rf_wen_in,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_rsp_valid,
  output logic            pc_wen,
  output logic            rf_wen,
  output logic            halt,
  output logic            fault
`ifdef CPU_SEQ_PERF_EN
  ,
  output logic [63:0]     perf_cycle,
  output logic [63:0]     perf_instret
`endif
);

  localparam int CW = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(IMEM_TIMEOUT - 1);
  localparam logic [31:0]   EBREAK_CMD = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_FETCH, S_IWAIT, S_EXEC, S_MREQ, S_MWAIT, S_HALT, S_FAULT
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   cmd_reg, cmd_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          load_reg, load_next;

  logic ifu_req_int, lsu_req_int, pc_wen_int, rf_wen_int;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_FETCH;
      cmd_reg   <= NOP_CMD;
      cnt_reg   <= '0;
      load_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cmd_reg   <= cmd_next;
      cnt_reg   <= cnt_next;
      load_reg  <= load_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cmd_next    = cmd_reg;
    cnt_next    = cnt_reg;
    load_next   = load_reg;
    ifu_req_int = 1'b0;
    lsu_req_int = 1'b0;
    pc_wen_int  = 1'b0;
    rf_wen_int  = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ifu_req_int = 1'b1;
        if (ifu_req_ready) begin
          state_next = S_IWAIT;
          cnt_next   = '0;
        end
      end
      S_IWAIT: begin
        if (ifu_rsp_valid) begin
          cmd_next   = ifu_rsp_data;
          state_next = S_EXEC;
        end else begin
          // The IMEM_TIMEOUT-th silent cycle leaves the counter at IMEM_TIMEOUT.
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST)
            state_next = S_FAULT;
        end
      end
      S_EXEC: begin
        if (cmd_reg == EBREAK_CMD) begin
          state_next = S_HALT;
        end else if (is_load || is_store) begin
          load_next  = is_load;
          state_next = S_MREQ;
        end else begin
          pc_wen_int = 1'b1;
          rf_wen_int = rf_wen_in;
          state_next = S_FETCH;
        end
      end
      S_MREQ: begin
        lsu_req_int = 1'b1;
        if (lsu_req_ready)
          state_next = S_MWAIT;
      end
      S_MWAIT: begin
        if (lsu_rsp_valid) begin
          pc_wen_int = 1'b1;
          rf_wen_int = rf_wen_in && load_reg;
          state_next = S_FETCH;
        end
      end
      S_HALT:  state_next = S_HALT;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is asserted so nothing leaks mid-reset.
  assign ifu_req_valid = rst && ifu_req_int;
  assign lsu_req_valid = rst && lsu_req_int;
  assign pc_wen        = rst && pc_wen_int;
  assign rf_wen        = rst && rf_wen_int;
  assign ifu_addr      = pc_in;
  assign cmd           = cmd_reg;
  assign halt          = (state_reg == S_HALT);
  assign fault         = (state_reg == S_FAULT);

`ifdef CPU_SEQ_PERF_EN
  logic [63:0] cycle_reg, instret_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else begin
      if (state_reg != S_HALT && state_reg != S_FAULT)
        cycle_reg <= cycle_reg + 64'd1;
      if (pc_wen_int)
        instret_reg <= instret_reg + 64'd1;
    end
  end

  assign perf_cycle   = cycle_reg;
  assign perf_instret = instret_reg;
`endif

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed cycle-by-cycle bench for cpu_step_sequencer.
// Inputs change 1 time unit after posedge; outputs are checked on the negedge.
module tb_cpu_step_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic [31:0] cmd;
  logic        is_load, is_store, rf_wen_in;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
  logic        pc_wen, rf_wen, halt, fault;
`ifdef CPU_SEQ_PERF_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  int checks_done  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  cpu_step_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_data  (ifu_rsp_data),
    .cmd           (cmd),
    .is_load       (is_load),
    .is_store      (is_store),
    .rf_wen_in     (rf_wen_in),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .pc_wen        (pc_wen),
    .rf_wen        (rf_wen),
    .halt          (halt),
    .fault         (fault)
`ifdef CPU_SEQ_PERF_EN
    ,
    .perf_cycle    (perf_cycle),
    .perf_instret  (perf_instret)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_done++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    ifu_req_ready = 0; ifu_rsp_valid = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
    is_load = 0; is_store = 0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 0; pc_in = 32'h100; ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_data = 0;
    is_load = 0; is_store = 0; rf_wen_in = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;

    // Reset state
    repeat (2) tick();
    settle();
    check("rst_cmd", cmd, 32'h0000_0013);
    check("rst_pc_wen", pc_wen, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_halt", halt, 0);
    check("rst_fault", fault, 0);
    check("rst_ifu_req", ifu_req_valid, 0);
    check("rst_lsu_req", lsu_req_valid, 0);

    // ALU op: FETCH, IWAIT, EXEC+commit
    tick(); rst = 1; ifu_req_ready = 1; settle();
    check("alu_c1_ifu_req", ifu_req_valid, 1);
    check("alu_c1_addr", ifu_addr, 32'h100);
    tick(); ifu_req_ready = 0; ifu_rsp_valid = 1; ifu_rsp_data = 32'h0050_0093; rf_wen_in = 1; settle();
    check("alu_c2_ifu_req", ifu_req_valid, 0);
    check("alu_c2_pc_wen", pc_wen, 0);
    tick(); ifu_rsp_valid = 0; settle();
    check("alu_c3_cmd", cmd, 32'h0050_0093);
    check("alu_c3_pc_wen", pc_wen, 1);
    check("alu_c3_rf_wen", rf_wen, 1);
    tick(); pc_in = 32'h104; ifu_req_ready = 1; settle();
    check("alu_c4_ifu_req", ifu_req_valid, 1);
    check("alu_c4_pc_wen", pc_wen, 0);
    check("alu_c4_addr", ifu_addr, 32'h104);

    // Load with lsu_req_ready low for 3 cycles
    tick(); ifu_req_ready = 0; ifu_rsp_valid = 1; ifu_rsp_data = 32'h0000_a103; settle();
    tick(); ifu_rsp_valid = 0; is_load = 1; settle();
    check("ld_exec_pc_wen", pc_wen, 0);
    check("ld_exec_lsu_req", lsu_req_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); lsu_req_ready = (i == 3); settle();
      check($sformatf("ld_mreq%0d_lsu_req", i), lsu_req_valid, 1);
      check($sformatf("ld_mreq%0d_pc_wen", i), pc_wen, 0);
    end
    tick(); lsu_req_ready = 0; settle();
    check("ld_mwait_lsu_req", lsu_req_valid, 0);
    check("ld_mwait_pc_wen", pc_wen, 0);
    tick(); lsu_rsp_valid = 1; settle();
    check("ld_commit_pc_wen", pc_wen, 1);
    check("ld_commit_rf_wen", rf_wen, 1);
    check("ld_commit_cmd", cmd, 32'h0000_a103);
    tick(); lsu_rsp_valid = 0; is_load = 0; ifu_req_ready = 1; settle();
    check("ld_after_pc_wen", pc_wen, 0);
    check("ld_after_ifu_req", ifu_req_valid, 1);

    // Store with rf_wen_in=1: commit without register write
    tick(); ifu_req_ready = 0; ifu_rsp_valid = 1; ifu_rsp_data = 32'h0020_a223; settle();
    tick(); ifu_rsp_valid = 0; is_store = 1; settle();
    tick(); lsu_req_ready = 1; settle();
    check("st_mreq_lsu_req", lsu_req_valid, 1);
    tick(); lsu_req_ready = 0; lsu_rsp_valid = 1; settle();
    check("st_commit_pc_wen", pc_wen, 1);
    check("st_commit_rf_wen", rf_wen, 0);
    tick(); lsu_rsp_valid = 0; is_store = 0; ifu_req_ready = 1; settle();
    check("st_after_ifu_req", ifu_req_valid, 1);

    // ebreak: halt without commit, sticky
    tick(); ifu_req_ready = 0; ifu_rsp_valid = 1; ifu_rsp_data = 32'h0010_0073; settle();
    tick(); ifu_rsp_valid = 0; ifu_req_ready = 1; settle();
    check("ebk_exec_pc_wen", pc_wen, 0);
    check("ebk_exec_rf_wen", rf_wen, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check($sformatf("ebk_halt%0d", i), halt, 1);
      check($sformatf("ebk_ifu_req%0d", i), ifu_req_valid, 0);
      check($sformatf("ebk_pc_wen%0d", i), pc_wen, 0);
    end
    tick(); apply_reset(); ifu_req_ready = 1; settle();
    check("ebk_rst_halt", halt, 0);
    check("ebk_rst_ifu_req", ifu_req_valid, 1);
    check("ebk_rst_cmd", cmd, 32'h0000_0013);

    // IMEM timeout: fault after 255 silent IWAIT cycles
    tick(); ifu_req_ready = 0; settle();
    check("to_iwait1_fault", fault, 0);
    repeat (254) tick();
    settle();
    check("to_iwait255_fault", fault, 0);
    tick(); settle();
    check("to_fault", fault, 1);
    check("to_fault_ifu_req", ifu_req_valid, 0);
    tick(); ifu_rsp_valid = 1; ifu_rsp_data = 32'h0050_0093; settle();
    tick(); ifu_rsp_valid = 0; settle();
    check("to_late_cmd", cmd, 32'h0000_0013);
    check("to_late_fault", fault, 1);
    check("to_late_pc_wen", pc_wen, 0);

    // Reset during MWAIT; stray LSU response afterwards
    tick(); apply_reset(); ifu_req_ready = 1; rf_wen_in = 1; settle();
    check("mr_fault_cleared", fault, 0);
    tick(); ifu_req_ready = 0; ifu_rsp_valid = 1; ifu_rsp_data = 32'h0000_a103; settle();
    tick(); ifu_rsp_valid = 0; is_load = 1; settle();
    tick(); lsu_req_ready = 1; settle();
    check("mr_mreq_lsu_req", lsu_req_valid, 1);
    tick(); lsu_req_ready = 0; settle();
    check("mr_mwait_lsu_req", lsu_req_valid, 0);
    tick(); rst = 0; settle();
    check("mr_in_rst_lsu_req", lsu_req_valid, 0);
    check("mr_in_rst_pc_wen", pc_wen, 0);
    tick(); tick(); rst = 1; is_load = 0; lsu_rsp_valid = 1; settle();
    check("mr_stray_pc_wen", pc_wen, 0);
    check("mr_stray_rf_wen", rf_wen, 0);
    check("mr_refetch_ifu_req", ifu_req_valid, 1);
    check("mr_refetch_lsu_req", lsu_req_valid, 0);
`ifdef CPU_SEQ_PERF_EN
    check("mr_perf_instret", perf_instret, 0);
    check("mr_perf_cycle0", perf_cycle, 0);
    tick(); lsu_rsp_valid = 0; settle();
    check("mr_perf_cycle1", perf_cycle, 1);
`else
    tick(); lsu_rsp_valid = 0; settle();
`endif
    check("mr_final_pc_wen", pc_wen, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_done);
    $finish;
  end

endmodule
